// File: rtl/handshake_pkg.sv
// Shared types and helpers for the credit-based round-robin arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, LOCKED)
//   index_width(): width of a requester index, never below one bit
package handshake_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // An index into n requesters needs at least one bit, even when n is 1 or 2
  function automatic int index_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Purely combinational round-robin pick.
// Scans req_i starting at ptr_i, wrapping modulo NUM_INPUTS, and returns
// the first set bit.
//   req_i    : request vector
//   ptr_i    : highest-priority requester this cycle
//   any_o    : at least one request is set
//   winner_o : index of the chosen requester (0 when any_o=0)
module rr_priority_pick
  import handshake_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int INDEX_WIDTH = index_width(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0]  req_i,
  input  logic [INDEX_WIDTH-1:0] ptr_i,
  output logic                   any_o,
  output logic [INDEX_WIDTH-1:0] winner_o
);

  int idx_s;

  // Walk offsets from farthest to nearest so the nearest request wins last
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    idx_s    = 0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      idx_s = int'(ptr_i) + i;
      // Explicit wrap so non-power-of-two sizes work
      if (idx_s >= NUM_INPUTS) begin
        idx_s = idx_s - NUM_INPUTS;
      end else begin
        idx_s = idx_s;
      end
      if (req_i[idx_s]) begin
        any_o    = 1'b1;
        winner_o = INDEX_WIDTH'(idx_s);
      end else begin
        any_o    = any_o;
      end
    end
  end

endmodule

// File: rtl/credit_rr_arbiter_dataless.sv
// Round-robin arbiter that shares one dataless downstream FIFO among
// NUM_INPUTS handshake channels. It gates grants with a credit counter that
// mirrors the free downstream slots.
//   clk, rst      : clock; synchronous active-high reset
//   ins_valid     : per-requester valid
//   ins_ready     : per-requester ready, one-hot in a transfer cycle
//   outs_valid    : token valid toward the shared FIFO
//   outs_ready    : shared FIFO ready
//   index         : granted requester, meaningful when outs_valid=1
//   credit_return : one pulse per slot freed downstream
//   credit_err    : sticky credit-overflow flag
module credit_rr_arbiter_dataless
  import handshake_pkg::*;
#(
  parameter  int NUM_INPUTS  = 2,
  parameter  int CREDITS     = 3,
  localparam int INDEX_WIDTH = index_width(NUM_INPUTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_INPUTS-1:0]  ins_valid,
  output logic [NUM_INPUTS-1:0]  ins_ready,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [INDEX_WIDTH-1:0] index,
  input  logic                   credit_return,
  output logic                   credit_err
);

  localparam int CW = $clog2(CREDITS + 1);

  arb_state_t             state_q, state_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [INDEX_WIDTH-1:0] lock_q, lock_d;
  logic [CW-1:0]          credits_q, credits_d;
  logic                   credit_err_q, credit_err_d;

  logic [NUM_INPUTS-1:0]  cand_s;
  logic                   any_s;
  logic [INDEX_WIDTH-1:0] pick_s;
  logic [INDEX_WIDTH-1:0] grant_s;
  logic [INDEX_WIDTH-1:0] ptr_next_s;
  logic                   valid_s;
  logic                   xfer_s;

  // Requests only count as candidates while credit remains
  always_comb begin
    if (credits_q != '0) begin
      cand_s = ins_valid;
    end else begin
      cand_s = '0;
    end
  end

  rr_priority_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_pick (
    .req_i   (cand_s),
    .ptr_i   (ptr_q),
    .any_o   (any_s),
    .winner_o(pick_s)
  );

  // Token offer: a fresh pick in IDLE, the held winner in LOCKED; nothing during reset
  always_comb begin
    if (rst) begin
      valid_s = 1'b0;
      grant_s = '0;
    end else if (state_q == LOCKED) begin
      valid_s = ins_valid[lock_q];
      grant_s = lock_q;
    end else begin
      valid_s = any_s;
      grant_s = pick_s;
    end
  end

  assign xfer_s     = valid_s & outs_ready;
  assign outs_valid = valid_s;
  assign index      = grant_s;
  assign credit_err = credit_err_q;
  assign ptr_next_s = (grant_s == INDEX_WIDTH'(NUM_INPUTS - 1)) ? '0
                                                                : grant_s + INDEX_WIDTH'(1);

  // Only the winner sees ready, and only in the transfer cycle
  always_comb begin
    ins_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      ins_ready[i] = xfer_s && (grant_s == INDEX_WIDTH'(i));
    end
  end

  // FSM, lock and pointer next state
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        // A stalled offer freezes the winner until it is taken
        if (valid_s && !outs_ready) begin
          state_d = LOCKED;
          lock_d  = grant_s;
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (xfer_s) begin
          state_d = IDLE;
        end else begin
          state_d = LOCKED;
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer_s) begin
      ptr_d = ptr_next_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Credit accounting: a simultaneous spend and return cancel out
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (xfer_s && !credit_return) begin
      credits_d = credits_q - CW'(1);
    end else if (!xfer_s && credit_return) begin
      if (credits_q == CW'(CREDITS)) begin
        credit_err_d = 1'b1;
      end else begin
        credits_d = credits_q + CW'(1);
      end
    end else begin
      credits_d = credits_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      lock_q       <= '0;
      credits_q    <= CW'(CREDITS);
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      lock_q       <= lock_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

endmodule

// File: tb/tb_credit_rr_arbiter_dataless.sv
// Directed self-checking bench for credit_rr_arbiter_dataless.
module tb_credit_rr_arbiter_dataless;

  logic       clk;
  logic       rst;
  logic [1:0] ins_valid;
  logic [1:0] ins_ready;
  logic       outs_valid;
  logic       outs_ready;
  logic [0:0] index;
  logic       credit_return;
  logic       credit_err;

  logic [2:0] ins_valid3;
  logic [2:0] ins_ready3;
  logic       outs_valid3;
  logic       outs_ready3;
  logic [1:0] index3;
  logic       credit_return3;
  logic       credit_err3;

  int tests;
  int failed;

  credit_rr_arbiter_dataless #(.NUM_INPUTS(2), .CREDITS(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .outs_valid   (outs_valid),
    .outs_ready   (outs_ready),
    .index        (index),
    .credit_return(credit_return),
    .credit_err   (credit_err)
  );

  credit_rr_arbiter_dataless #(.NUM_INPUTS(3), .CREDITS(3)) u3 (
    .clk          (clk),
    .rst          (rst),
    .ins_valid    (ins_valid3),
    .ins_ready    (ins_ready3),
    .outs_valid   (outs_valid3),
    .outs_ready   (outs_ready3),
    .index        (index3),
    .credit_return(credit_return3),
    .credit_err   (credit_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  initial begin
    logic [0:0] exp_idx [3];
    logic [1:0] exp_rdy [3];
    tests = 0;
    failed = 0;
    exp_idx[0] = 1'b0; exp_idx[1] = 1'b1; exp_idx[2] = 1'b0;
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01;

    rst = 1'b1;
    ins_valid = 2'b00; outs_ready = 1'b0; credit_return = 1'b0;
    ins_valid3 = 3'b000; outs_ready3 = 1'b0; credit_return3 = 1'b0;
    tick; tick;
    rst = 1'b0;
    settle;
    chk("rst_outs_valid", outs_valid, 1'b0);
    chk("rst_ins_ready", ins_ready, 2'b00);
    chk("rst_index", index, 1'b0);
    chk("rst_credit_err", credit_err, 1'b0);
    chk("rst_credits", dut.credits_q, 2'd3);

    // Alternating grants until credits run out
    tick;
    ins_valid = 2'b11; outs_ready = 1'b1;
    settle;
    for (int k = 0; k < 3; k++) begin
      chk("rr_credits", dut.credits_q, 32'(3 - k));
      chk("rr_valid", outs_valid, 1'b1);
      chk("rr_index", index, exp_idx[k]);
      chk("rr_ready", ins_ready, exp_rdy[k]);
      tick;
      settle;
    end
    chk("rr_empty_credits", dut.credits_q, 2'd0);
    chk("rr_empty_valid", outs_valid, 1'b0);
    chk("rr_empty_ready", ins_ready, 2'b00);

    // Single credit return at zero: eligible exactly one cycle later
    credit_return = 1'b1;
    settle;
    chk("ret_same_cycle_valid", outs_valid, 1'b0);
    tick;
    credit_return = 1'b0;
    settle;
    chk("ret_next_valid", outs_valid, 1'b1);
    chk("ret_next_index", index, 1'b1);
    chk("ret_next_ready", ins_ready, 2'b10);
    tick;
    settle;
    chk("ret_drained_credits", dut.credits_q, 2'd0);
    chk("ret_drained_valid", outs_valid, 1'b0);

    // Bring credits to 2, then spend and return in the same cycle
    ins_valid = 2'b00; credit_return = 1'b1;
    tick; tick;
    credit_return = 1'b0;
    settle;
    chk("same_pre_credits", dut.credits_q, 2'd2);
    ins_valid = 2'b01; credit_return = 1'b1;
    settle;
    chk("same_ready", ins_ready, 2'b01);
    tick;
    ins_valid = 2'b00; credit_return = 1'b0;
    settle;
    chk("same_credits", dut.credits_q, 2'd2);
    chk("same_err", credit_err, 1'b0);

    // Back to full credits; ptr is now 1
    credit_return = 1'b1;
    tick;
    credit_return = 1'b0;
    settle;
    chk("lock_pre_credits", dut.credits_q, 2'd3);

    // Stalled offer locks onto requester 0
    ins_valid = 2'b01; outs_ready = 1'b0;
    settle;
    chk("lock_a_valid", outs_valid, 1'b1);
    chk("lock_a_index", index, 1'b0);
    chk("lock_a_ready", ins_ready, 2'b00);
    tick;
    settle;
    chk("lock_b_index", index, 1'b0);
    tick;
    ins_valid = 2'b10;
    settle;
    chk("lock_drop_valid", outs_valid, 1'b0);
    chk("lock_drop_ready", ins_ready, 2'b00);
    tick;
    ins_valid = 2'b11;
    settle;
    chk("lock_hold_valid", outs_valid, 1'b1);
    chk("lock_hold_index", index, 1'b0);
    tick;
    outs_ready = 1'b1;
    settle;
    chk("lock_xfer_index", index, 1'b0);
    chk("lock_xfer_ready", ins_ready, 2'b01);
    tick;
    settle;
    chk("lock_after_credits", dut.credits_q, 2'd2);
    chk("lock_next_index", index, 1'b1);
    chk("lock_next_ready", ins_ready, 2'b10);
    tick;
    ins_valid = 2'b00; outs_ready = 1'b0;
    settle;
    chk("lock_end_credits", dut.credits_q, 2'd1);

    // Overflow the counter and confirm the flag is sticky
    credit_return = 1'b1;
    tick; tick;
    settle;
    chk("err_not_yet", credit_err, 1'b0);
    chk("err_full_credits", dut.credits_q, 2'd3);
    tick;
    credit_return = 1'b0;
    settle;
    chk("err_set", credit_err, 1'b1);
    chk("err_saturated", dut.credits_q, 2'd3);
    ins_valid = 2'b01; outs_ready = 1'b1;
    tick;
    ins_valid = 2'b00; outs_ready = 1'b0;
    settle;
    chk("err_sticky", credit_err, 1'b1);
    chk("err_traffic_credits", dut.credits_q, 2'd2);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    settle;
    chk("err_cleared", credit_err, 1'b0);
    chk("err_rst_credits", dut.credits_q, 2'd3);

    // Three requesters: move ptr to 2, then check the wrap
    ins_valid3 = 3'b010; outs_ready3 = 1'b1;
    settle;
    chk("n3_first_index", index3, 2'd1);
    tick;
    settle;
    chk("n3_ptr2", u3.ptr_q, 2'd2);
    ins_valid3 = 3'b011; outs_ready3 = 1'b0;
    settle;
    chk("n3_wrap_index", index3, 2'd0);
    chk("n3_wrap_valid", outs_valid3, 1'b1);
    tick;
    outs_ready3 = 1'b1;
    settle;
    chk("n3_xfer_ready", ins_ready3, 3'b001);
    tick;
    outs_ready3 = 1'b0;
    settle;
    chk("n3_ptr1", u3.ptr_q, 2'd1);
    chk("n3_credits", u3.credits_q, 2'd1);
    chk("n3_lock_index", index3, 2'd1);
    tick;
    rst = 1'b1;
    settle;
    chk("n3_rst_valid", outs_valid3, 1'b0);
    chk("n3_rst_ready", ins_ready3, 3'b000);
    tick;
    rst = 1'b0;
    settle;
    chk("n3_rst_credits", u3.credits_q, 2'd3);
    chk("n3_rst_ptr", u3.ptr_q, 2'd0);
    chk("n3_rst_unlocked_index", index3, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
